// File: rtl/and_unit.sv
// Parameterised bitwise AND leaf cell: combinational result plus a registered
// copy with a one-cycle valid strobe and all/any reduction status flags.
module and_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             all_set,
  output logic             any_set
);

  // All bits of the word are 1.
  function automatic logic reduce_all(input logic [WIDTH-1:0] v);
    return &v;
  endfunction

  // At least one bit of the word is 1.
  function automatic logic reduce_any(input logic [WIDTH-1:0] v);
    return |v;
  endfunction

  logic [WIDTH-1:0] and_s;
  logic [WIDTH-1:0] q_next_s;
  logic             valid_next_s;
  logic             all_next_s;
  logic             any_next_s;

  logic [WIDTH-1:0] q_r;
  logic             valid_r;
  logic             all_r;
  logic             any_r;

  // Pure gate path, independent of clock and reset so it stays live in reset.
  assign and_s = a & b;
  assign out   = and_s;

  // Next-state selection: capture on in_valid, otherwise hold the result.
  // Flags are derived from the value being loaded, so they change on the
  // same edge as out_q while still coming straight from flops.
  always_comb begin
    q_next_s     = q_r;
    valid_next_s = 1'b0;
    all_next_s   = all_r;
    any_next_s   = any_r;
    if (in_valid) begin
      q_next_s     = and_s;
      valid_next_s = 1'b1;
      all_next_s   = reduce_all(and_s);
      any_next_s   = reduce_any(and_s);
    end else begin
      q_next_s     = q_r;
      valid_next_s = 1'b0;
      all_next_s   = all_r;
      any_next_s   = any_r;
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r     <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      all_r   <= 1'b0;
      any_r   <= 1'b0;
    end else begin
      q_r     <= q_next_s;
      valid_r <= valid_next_s;
      all_r   <= all_next_s;
      any_r   <= any_next_s;
    end
  end

  assign out_q     = q_r;
  assign out_valid = valid_r;
  assign all_set   = all_r;
  assign any_set   = any_r;

endmodule

// File: tb/tb_and_unit.sv
// Scoreboard bench for and_unit: WIDTH=1 truth table plus a WIDTH=16 instance
// driven with directed and random traffic, checked by a separate monitor.
module tb_and_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] a16, b16;
  logic        v16;
  logic [15:0] out16, q16;
  logic        ov16, all16, any16;
  logic        a1, b1, v1;
  logic        out1, q1, ov1, all1, any1;

  int n_checks;
  int n_fail;
  int push_cnt;
  int pop_cnt;
  logic [15:0] exp_q[$];
  logic [15:0] last_q;

  and_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .in_valid(v16),
    .out(out16), .out_q(q16), .out_valid(ov16), .all_set(all16), .any_set(any16)
  );

  and_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .out(out1), .out_q(q1), .out_valid(ov1), .all_set(all1), .any_set(any1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: bit i of the result is 1 exactly when both operand bits are 1.
  function automatic logic [15:0] ref_and(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 16; i++)
      if (x[i] == 1'b1 && y[i] == 1'b1) r = r + (16'h0001 << i);
    return r;
  endfunction

  // Scoreboard producer: every accepted request yields one expected result.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && v16 === 1'b1) begin
      exp_q.push_back(ref_and(a16, b16));
      push_cnt++;
    end
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n !== 1'b1) begin
      last_q = 16'h0000;
      check("rst_q", {48'h0, q16}, 64'h0);
      check("rst_valid", {63'h0, ov16}, 64'h0);
      check("rst_flags", {62'h0, all16, any16}, 64'h0);
    end else if (ov16 === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'h1, 64'h0);
      end else begin
        e = exp_q.pop_front();
        pop_cnt++;
        last_q = e;
        check("sb_q", {48'h0, q16}, {48'h0, e});
        check("sb_all", {63'h0, all16}, {63'h0, (e == 16'hFFFF)});
        check("sb_any", {63'h0, any16}, {63'h0, (e != 16'h0000)});
      end
    end else begin
      check("hold_q", {48'h0, q16}, {48'h0, last_q});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] tt_a, tt_b, tt_o, sv;
    n_checks = 0; n_fail = 0; push_cnt = 0; pop_cnt = 0; last_q = 16'h0000;
    rst_n = 1'b0; a16 = 16'h0000; b16 = 16'h0000; v16 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    #1;
    check("reset_q", {48'h0, q16}, 64'h0);
    check("reset_valid", {63'h0, ov16}, 64'h0);
    check("reset_flags1", {61'h0, q1, all1, any1}, 64'h0);

    // WIDTH=1 truth table, combinational, 10 ns apart
    tt_a = 16'h000C; tt_b = 16'h000A; tt_o = 16'h0008;
    for (int i = 3; i >= 0; i--) begin
      a1 = tt_a[i]; b1 = tt_b[i];
      #0;
      #0;
      check("tt_out1", {63'h0, out1}, {63'h0, tt_o[i]});
      #10;
    end
    rst_n = 1'b1;

    // WIDTH=1 registered boundary: flags track out_q
    cyc(); a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    cyc(); v1 = 1'b0;
    check("w1_set", {60'h0, ov1, q1, all1, any1}, 64'hF);
    a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
    cyc(); v1 = 1'b0;
    check("w1_clr", {60'h0, ov1, q1, all1, any1}, 64'h8);

    // Registered capture
    cyc(); a16 = 16'hF0F0; b16 = 16'hFF00; v16 = 1'b1;
    #1 check("cap_out", {48'h0, out16}, 64'hF000);
    cyc(); v16 = 1'b0;
    check("cap_q", {48'h0, q16}, 64'hF000);
    check("cap_flags", {61'h0, ov16, all16, any16}, 64'h5);
    cyc();
    check("cap_hold", {47'h0, ov16, q16}, 64'h0F000);

    // Reduction extremes
    a16 = 16'hFFFF; b16 = 16'hFFFF; v16 = 1'b1;
    cyc(); a16 = 16'h0000;
    check("ext_ones", {46'h0, all16, any16, q16}, 64'h3FFFF);
    cyc(); v16 = 1'b0;
    check("ext_zero", {46'h0, all16, any16, q16}, 64'h0);
    check("ext_zero_out", {48'h0, out16}, 64'h0);

    // Streaming, four back-to-back requests
    b16 = 16'h000F;
    sv = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k > 0) check("stream_mid", {47'h0, ov16, q16}, {47'h0, 1'b1, sv});
      a16 = (16'h0002 << k) - 16'h0001; v16 = 1'b1;
      sv = a16;
    end
    cyc(); v16 = 1'b0;
    check("stream_last", {47'h0, ov16, q16}, 64'h1000F);
    cyc();
    check("stream_end", {63'h0, ov16}, 64'h0);

    // Async reset mid-cycle after an all-ones capture, with a coincident pulse
    a16 = 16'hFFFF; b16 = 16'hFFFF; v16 = 1'b1;
    cyc(); v16 = 1'b0;
    check("pre_rst", {46'h0, all16, any16, q16}, 64'h3FFFF);
    @(negedge clk); #2;
    a16 = 16'h5A5A; b16 = 16'h0FF0; v16 = 1'b1; rst_n = 1'b0;
    #1;
    check("arst_regs", {45'h0, ov16, all16, any16, q16}, 64'h0);
    check("arst_out", {48'h0, out16}, 64'h0A50);
    cyc();
    check("arst_drop", {45'h0, ov16, all16, any16, q16}, 64'h0);
    @(negedge clk); #2; rst_n = 1'b1;
    cyc(); v16 = 1'b0;
    check("post_rst", {47'h0, ov16, q16}, 64'h10A50);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      cyc();
      case ($urandom_range(0, 3))
        0: a16 = 16'hFFFF;
        1: a16 = 16'h0000;
        default: a16 = 16'($urandom);
      endcase
      b16 = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      v16 = 1'($urandom_range(0, 1));
      #1 check("rnd_out", {48'h0, out16}, {48'h0, ref_and(a16, b16)});
    end
    cyc(); v16 = 1'b0;
    cyc(); cyc();
    check("sb_drained", 64'(exp_q.size()), 64'h0);
    check("sb_count", 64'(pop_cnt), 64'(push_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
